// File: rtl/esc_pkg.sv
// Shared types and helpers for the six-step ESC ramp sequencer: FSM states,
// coil patterns per commutation step, step sequencing and period clamping.
package esc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RAMP  = 3'd2,
        RUN   = 3'd3,
        DECEL = 3'd4,
        STOP  = 3'd5
    } esc_state_e;

    // {C,B,A} per step; index 0 (off) and the unused code 7 both de-energise.
    localparam logic [2:0] COIL_LUT [8] = '{
        3'b000, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b000
    };

    // Wide enough for any period width the sequencer is built with.
    localparam int unsigned CLAMP_W = 64;

    function automatic logic [2:0] next_step(input logic [2:0] step, input logic rev);
        if (!rev) begin
            return (step >= 3'd6 || step == 3'd0) ? 3'd1 : step + 3'd1;
        end
        return (step <= 3'd1) ? 3'd6 : step - 3'd1;
    endfunction

    function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] value,
                                                 input logic [CLAMP_W-1:0] lo,
                                                 input logic [CLAMP_W-1:0] hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/esc_period_timer.sv
// Loadable commutation interval counter: counts 0..period-1 while running and
// pulses tick on the terminal count; the period is re-sampled at every tick.
module esc_period_timer #(
    parameter int unsigned PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                _rst,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;

    assign tick = run && (cnt_q == period_q - PERIOD_W'(1));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d    = cnt_q + PERIOD_W'(1);
        period_d = period_q;
        if (!run || tick) begin
            cnt_d    = '0;
            period_d = period;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/esc_ramp_sequencer.sv
// Open-loop six-step start-up sequencer: align, ramp the commutation period to
// the target, hold, follow target changes and decelerate to a stop.
module esc_ramp_sequencer
    import esc_pkg::*;
#(
    parameter int unsigned PERIOD_W     = 32,
    parameter int unsigned START_PERIOD = 2_000_000,
    parameter int unsigned MIN_PERIOD   = 50_000,
    parameter int unsigned RAMP_STEP    = 1_000,
    parameter int unsigned ALIGN_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                _rst,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] target_period,
    output logic [2:0]          coil,
    output logic [2:0]          step_idx,
    output logic                step_tick,
    output logic                running,
    output logic                at_speed,
    output logic [2:0]          state_o
);

    localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] ALIGN_LAST = PERIOD_W'(ALIGN_CYCLES - 1);
    localparam logic [PERIOD_W:0]   STEP_X     = (PERIOD_W+1)'(RAMP_STEP);

    esc_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
    logic [PERIOD_W-1:0] align_cnt_q, align_cnt_d;
    logic [2:0]          step_q, step_d;
    logic                dir_q, dir_d;
    logic                step_tick_q, step_tick_d;
    logic [2:0]          coil_q, coil_d;
    logic                running_q, running_d;
    logic                at_speed_q, at_speed_d;

    logic [PERIOD_W-1:0] eff_target;
    logic [PERIOD_W:0]   dec_wide, inc_wide;
    logic [PERIOD_W-1:0] dec_period, inc_to_target, inc_to_start;
    logic                tick, timer_run;

    assign eff_target = PERIOD_W'(clamp(CLAMP_W'(target_period), CLAMP_W'(MIN_PERIOD),
                                        CLAMP_W'(START_PERIOD)));
    assign timer_run  = state_q inside {RAMP, RUN, DECEL, STOP};

    esc_period_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk   (clk),
        ._rst  (_rst),
        .run   (timer_run),
        .period(cur_period_d),
        .tick  (tick)
    );

    // One extra bit keeps the step subtraction and addition free of wrap-around.
    always_comb begin
        dec_wide      = {1'b0, cur_period_q} - STEP_X;
        inc_wide      = {1'b0, cur_period_q} + STEP_X;
        dec_period    = (dec_wide[PERIOD_W] || (dec_wide[PERIOD_W-1:0] < eff_target))
                        ? eff_target : dec_wide[PERIOD_W-1:0];
        inc_to_target = (inc_wide > {1'b0, eff_target}) ? eff_target : inc_wide[PERIOD_W-1:0];
        inc_to_start  = (inc_wide > {1'b0, START_P}) ? START_P : inc_wide[PERIOD_W-1:0];
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q      <= IDLE;
            cur_period_q <= START_P;
            align_cnt_q  <= '0;
            dir_q        <= 1'b0;
            step_q       <= '0;
            step_tick_q  <= 1'b0;
            coil_q       <= '0;
            running_q    <= 1'b0;
            at_speed_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_period_q <= cur_period_d;
            align_cnt_q  <= align_cnt_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            step_tick_q  <= step_tick_d;
            coil_q       <= coil_d;
            running_q    <= running_d;
            at_speed_q   <= at_speed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        align_cnt_d  = '0;
        dir_d        = dir_q;
        step_d       = step_q;
        step_tick_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                step_d       = 3'd0;
                cur_period_d = START_P;
                if (enable) begin
                    state_d = ALIGN;
                    dir_d   = dir;
                    step_d  = 3'd1;
                end
            end
            ALIGN: begin
                align_cnt_d = align_cnt_q + PERIOD_W'(1);
                if (!enable) begin
                    state_d = IDLE;
                    step_d  = 3'd0;
                end else if (align_cnt_q == ALIGN_LAST) begin
                    state_d      = RAMP;
                    cur_period_d = START_P;
                end
            end
            RAMP: begin
                if (tick) begin
                    step_d      = next_step(step_q, dir_q);
                    step_tick_d = 1'b1;
                    // A target raised mid-ramp is approached gradually, not jumped to.
                    if (eff_target > cur_period_q) begin
                        state_d = DECEL;
                    end else begin
                        cur_period_d = dec_period;
                        if (dec_period == eff_target) state_d = RUN;
                    end
                end
                if (!enable) state_d = STOP;
            end
            RUN: begin
                if (tick) begin
                    step_d      = next_step(step_q, dir_q);
                    step_tick_d = 1'b1;
                end
                if (eff_target < cur_period_q)      state_d = RAMP;
                else if (eff_target > cur_period_q) state_d = DECEL;
                if (!enable) state_d = STOP;
            end
            DECEL: begin
                if (tick) begin
                    step_d      = next_step(step_q, dir_q);
                    step_tick_d = 1'b1;
                end
                if (eff_target < cur_period_q) begin
                    state_d = RAMP;
                end else if (tick) begin
                    cur_period_d = inc_to_target;
                    if (inc_to_target == eff_target) state_d = RUN;
                end
                if (!enable) state_d = STOP;
            end
            STOP: begin
                if (enable) begin
                    state_d = RAMP;
                    if (tick) begin
                        step_d      = next_step(step_q, dir_q);
                        step_tick_d = 1'b1;
                    end
                end else if (tick) begin
                    if (cur_period_q < START_P) begin
                        step_d       = next_step(step_q, dir_q);
                        step_tick_d  = 1'b1;
                        cur_period_d = inc_to_start;
                    end else begin
                        state_d = IDLE;
                        step_d  = 3'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from next-state values and registered, so they change on the tick edge.
    always_comb begin
        coil_d     = COIL_LUT[step_d];
        running_d  = state_d inside {RAMP, RUN, DECEL, STOP};
        at_speed_d = (state_d == RUN);
    end

    assign coil      = coil_q;
    assign step_idx  = step_q;
    assign step_tick = step_tick_q;
    assign running   = running_q;
    assign at_speed  = at_speed_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_esc_ramp_sequencer.sv
// Directed bench for esc_ramp_sequencer with a small, fast configuration:
// START=20, MIN=4, STEP=4, ALIGN=10.
module tb_esc_ramp_sequencer;

    localparam int S_IDLE  = 0;
    localparam int S_ALIGN = 1;
    localparam int S_RAMP  = 2;
    localparam int S_RUN   = 3;
    localparam int S_DECEL = 4;
    localparam int S_STOP  = 5;

    logic        clk = 1'b0;
    logic        _rst;
    logic        enable;
    logic        dir;
    logic [31:0] target_period;
    logic [2:0]  coil;
    logic [2:0]  step_idx;
    logic        step_tick;
    logic        running;
    logic        at_speed;
    logic [2:0]  state_o;

    int n_assert = 0;
    int n_fail   = 0;

    esc_ramp_sequencer #(
        .PERIOD_W    (32),
        .START_PERIOD(20),
        .MIN_PERIOD  (4),
        .RAMP_STEP   (4),
        .ALIGN_CYCLES(10)
    ) dut (
        .clk          (clk),
        ._rst         (_rst),
        .enable       (enable),
        .dir          (dir),
        .target_period(target_period),
        .coil         (coil),
        .step_idx     (step_idx),
        .step_tick    (step_tick),
        .running      (running),
        .at_speed     (at_speed),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_coil(input int step);
        case (step)
            1:       return 3'b011;
            2:       return 3'b001;
            3:       return 3'b101;
            4:       return 3'b100;
            5:       return 3'b110;
            6:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({coil, step_idx, step_tick, running, at_speed, state_o});
    endfunction

    // Counts negedges until the next step_tick; checks interval and the new step.
    task automatic tick_step(input string tag, input int exp_len, input int exp_step,
                             input int exp_state);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step_tick !== 1'b1 && n < 200);
        check({tag, "_len"},   32'(n),        32'(exp_len));
        check({tag, "_step"},  32'(step_idx), 32'(exp_step));
        check({tag, "_coil"},  32'(coil),     32'(ref_coil(exp_step)));
        check({tag, "_state"}, 32'(state_o),  32'(exp_state));
    endtask

    // Called one cycle before the edge that enters ALIGN.
    task automatic check_align(input string tag);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (state_o == 3'(S_ALIGN) && n < 100) begin
            if (coil !== 3'b011 || step_idx !== 3'd1 || step_tick !== 1'b0 || running !== 1'b0)
                ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check({tag, "_len"},  32'(n),       32'd10);
        check({tag, "_outs"}, 32'(ok),      32'd1);
        check({tag, "_next"}, 32'(state_o), 32'(S_RAMP));
        check({tag, "_run"},  32'(running), 32'd1);
    endtask

    initial begin
        int  n;
        bit  saw_tick;

        _rst          = 1'b0;
        enable        = 1'b0;
        dir           = 1'b0;
        target_period = 32'd8;
        #3;
        check("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        _rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", all_outs(), 32'd0);

        // Forward spin-up to 8, then a few RUN steps including the 6->1 wrap.
        enable = 1'b1;
        check_align("fwd_align");
        tick_step("fwd_t1", 20, 2, S_RAMP);
        check("fwd_t1_atspd", 32'(at_speed), 32'd0);
        @(negedge clk);
        check("fwd_tick_pulse", 32'(step_tick), 32'd0);
        tick_step("fwd_t2", 15, 3, S_RAMP);
        tick_step("fwd_t3", 12, 4, S_RUN);
        check("fwd_atspd", 32'(at_speed), 32'd1);
        tick_step("fwd_t4", 8, 5, S_RUN);
        tick_step("fwd_t5", 8, 6, S_RUN);
        tick_step("fwd_t6", 8, 1, S_RUN);

        // Stop from 8: remaining interval, then 12, 16, and a silent 20 into IDLE.
        enable = 1'b0;
        tick_step("stop_t1", 8, 2, S_STOP);
        check("stop_atspd", 32'(at_speed), 32'd0);
        tick_step("stop_t2", 12, 3, S_STOP);
        tick_step("stop_t3", 16, 4, S_STOP);
        n        = 0;
        saw_tick = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (step_tick) saw_tick = 1'b1;
        end while (state_o != 3'(S_IDLE) && n < 200);
        check("stop_idle_len", 32'(n), 32'd20);
        check("stop_no_tick", 32'(saw_tick), 32'd0);
        check("stop_idle_outs", all_outs(), 32'd0);

        // Reverse spin-up; a dir change while running must be ignored.
        dir    = 1'b1;
        enable = 1'b1;
        check_align("rev_align");
        tick_step("rev_t1", 20, 6, S_RAMP);
        tick_step("rev_t2", 16, 5, S_RAMP);
        tick_step("rev_t3", 12, 4, S_RUN);
        dir = 1'b0;
        tick_step("rev_dirtog", 8, 3, S_RUN);

        // Slow down to 16, then speed up to a target clamped to MIN (4).
        target_period = 32'd16;
        @(negedge clk);
        check("decel_entry", 32'(state_o), 32'(S_DECEL));
        check("decel_entry_atspd", 32'(at_speed), 32'd0);
        tick_step("decel_t1", 7, 2, S_DECEL);
        tick_step("decel_t2", 12, 1, S_RUN);
        check("decel_atspd", 32'(at_speed), 32'd1);
        tick_step("run16", 16, 6, S_RUN);
        target_period = 32'd0;
        tick_step("ramp_t1", 16, 5, S_RAMP);
        tick_step("ramp_t2", 12, 4, S_RAMP);
        tick_step("ramp_t3", 8, 3, S_RUN);
        tick_step("clamp_lo", 4, 2, S_RUN);
        tick_step("clamp_lo2", 4, 1, S_RUN);

        // Reset while running, restart with a target clamped to START (20).
        target_period = 32'd100;
        dir           = 1'b0;
        #2 _rst = 1'b0;
        #1 check("rst_run_outs", all_outs(), 32'd0);
        @(negedge clk);
        _rst = 1'b1;
        check_align("rst1_align");
        tick_step("clamp_hi_t1", 20, 2, S_RUN);
        check("clamp_hi_atspd", 32'(at_speed), 32'd1);
        tick_step("clamp_hi_t2", 20, 3, S_RUN);

        // Reset between clock edges in the middle of a ramp.
        target_period = 32'd8;
        tick_step("ramp2_t1", 20, 4, S_RAMP);
        repeat (3) @(negedge clk);
        check("pre_rst_state", 32'(state_o), 32'(S_RAMP));
        #2 _rst = 1'b0;
        #1 check("rst_ramp_outs", all_outs(), 32'd0);
        @(negedge clk);
        _rst = 1'b1;
        check_align("rst2_align");
        tick_step("post_rst_t1", 20, 2, S_RAMP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/esc_ramp_sequencer.md
Name: esc_ramp_sequencer

Overview:
Open-loop start-up and speed sequencer for the six-step brushless ESC. It aligns the rotor, then ramps the commutation period from a slow start value down to a requested target period. It holds that speed and decelerates to stop when disabled. It drives the three coil enables directly and exports a per-step tick and the step index for the rest of the ESC.

Parameters:
PERIOD_W, 32, width of all period/count quantities
START_PERIOD, 2_000_000, commutation interval (clk cycles) at ramp start and stop threshold
MIN_PERIOD, 50_000, shortest legal interval (max speed)
RAMP_STEP, 1_000, period change applied at each commutation tick while ramping
ALIGN_CYCLES, 1_000_000, clk cycles the rotor is held on step 1 before ramping

Ports:
clk  input  1  system clock, single clock domain
_rst  input  1  asynchronous, active-low reset
enable  input  1  1 = run motor, 0 = decelerate and stop
dir  input  1  0 = forward sequence, 1 = reverse; sampled only in IDLE
target_period  input  PERIOD_W  requested commutation interval in clk cycles
coil  output  3  {C,B,A} coil enables
step_idx  output  3  current step 1..6, 0 when off
step_tick  output  1  one-clk pulse on each step advance
running  output  1  high in RAMP, RUN, DECEL, STOP
at_speed  output  1  high in RUN
state_o  output  3  current FSM state encoding, for debug

Behaviour:
- Reset (async, _rst=0):
  - state=IDLE, cur_period=START_PERIOD, interval counter=0, dir_q=0.
  - All outputs 0.
- Coil patterns {C,B,A} per step: 1=011 (AB), 2=001 (A), 3=101 (AC), 4=100 (C), 5=110 (BC), 6=010 (B). Step 0 gives 000.
- All outputs are registered. step_idx and coil update on the same edge that raises step_tick.
- eff_target = clamp(target_period, MIN_PERIOD, START_PERIOD). It is re-evaluated every cycle.
- Interval counter:
  - Counts 0..cur_period-1 in RAMP/RUN/DECEL/STOP.
  - At terminal count a tick event fires and the counter returns to 0.
  - A cur_period update made at a tick applies to the next interval.
- Step advance on a tick event:
  - dir_q=0: 1→2→…→6→1.
  - dir_q=1: 1→6→5→…→2→1.
- Period arithmetic:
  - Decrease: cur_period = max(cur_period−RAMP_STEP, eff_target). Underflow-safe, computed at PERIOD_W+1 bits.
  - Increase: saturates at the relevant ceiling (eff_target or START_PERIOD).
- States:
  - IDLE: coil=000, step_idx=0.
    - enable=1 → ALIGN; latch dir_q=dir.
  - ALIGN: step_idx=1, coil=011 for ALIGN_CYCLES clocks. No tick is issued.
    - enable=0 → IDLE next cycle.
    - Align count done → RAMP with cur_period=START_PERIOD and counter=0.
  - RAMP: at each tick, advance step and decrease the period.
    - If the new cur_period == eff_target → RUN.
    - enable=0 → STOP; the current interval continues.
  - RUN: at each tick, advance step; cur_period unchanged.
    - eff_target < cur_period → RAMP.
    - eff_target > cur_period → DECEL.
    - enable=0 → STOP.
  - DECEL: at each tick, advance step; cur_period = min(cur_period+RAMP_STEP, eff_target).
    - If the result equals eff_target → RUN.
    - eff_target < cur_period → RAMP.
    - enable=0 → STOP.
  - STOP: at each tick, if cur_period < START_PERIOD, advance step and set cur_period = min(cur_period+RAMP_STEP, START_PERIOD).
    - At a tick with cur_period == START_PERIOD → IDLE; no step_tick, coil=000 next cycle.
    - enable=1 → RAMP at once; the period continues from its current value.
- Simultaneous events:
  - enable deassert on a tick cycle: the tick is processed per the current state, then the state moves to STOP.
  - Direction changes outside IDLE are ignored.
- Reset mid-operation forces IDLE outputs immediately, without waiting for a clock edge.

Decomposition:
- Package esc_pkg holds:
  - state enum (IDLE, ALIGN, RAMP, RUN, DECEL, STOP);
  - the 6-entry coil pattern constant array indexed by step;
  - a next_step(step, dir) function;
  - the clamp function.
- One sub-module, esc_period_timer, implements the loadable interval counter:
  - inputs clk, _rst, run, period;
  - output tick;
  - the period is sampled at each tick.
- The FSM and period arithmetic stay in the top level.

Test Plan:
All scenarios use START_PERIOD=20, MIN_PERIOD=4, RAMP_STEP=4, ALIGN_CYCLES=10.
- Spin-up, forward: enable=1, dir=0, target=8.
  - ALIGN: 10 clks with coil=011, step_idx=1.
  - Tick intervals 20,16,12,8; step_idx 2,3,4,5.
  - at_speed=1 after the tick that loads 8; intervals stay 8.
- Reverse: dir=1 at enable.
  - step_idx sequence 1,6,5,4 with coil 011,010,110,100.
  - dir toggled mid-RUN → sequence unchanged.
- Clamping:
  - target=0 → settles at interval 4.
  - target=100 → at_speed from the first RAMP tick, interval 20.
- Stop: enable=0 in RUN at 8.
  - Remaining interval, then intervals 12,16,20.
  - Then IDLE: coil=000, step_idx=0, running=0, no final step_tick.
- Speed change:
  - RUN at 8, target→16 → DECEL intervals 12,16 → RUN.
  - target→4 → RAMP intervals 4 → RUN.
- Async reset:
  - Assert _rst=0 mid-RAMP between clock edges → all outputs 0 immediately.
  - Release with enable=1 → ALIGN restarts with a full 10 clks.
